// File: rtl/seq_alu_if.sv
// Handshake and operand/result bundle between the controller and seq_alu.
interface seq_alu_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
);
  logic             start;
  logic [5:0]       funct;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SHW-1:0]   shamt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;

  modport master (
    output start, funct, a, b, shamt,
    input  busy, done, result, zero, overflow
  );

  modport slave (
    input  start, funct, a, b, shamt,
    output busy, done, result, zero, overflow
  );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle MIPS ALU: single-cycle logic/arith ops, iterative SRL and
// MULTU (shift-add) with internal HI/LO, start/busy/done handshake.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic     clk,
  input  logic     rst_n,
  seq_alu_if.slave bus
);

  localparam int CW = SHW + 1;

  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  typedef enum logic [1:0] {IDLE, SHIFT, MULT, DONE} state_t;

  state_t             state, state_nx;
  logic [WIDTH-1:0]   a_q, hi, lo;
  logic [2*WIDTH-1:0] prod;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   alu_res, add_res, sub_res, sh_next;
  logic               alu_ovf;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic               last_iter;

  // Single-cycle ALU evaluated directly on the bus operands at accept time
  always_comb begin
    add_res = bus.a + bus.b;
    sub_res = bus.a + ~bus.b + WIDTH'(1);
    alu_res = '0;
    alu_ovf = 1'b0;
    case (bus.funct)
      F_AND: alu_res = bus.a & bus.b;
      F_OR:  alu_res = bus.a | bus.b;
      F_ADD: begin
        alu_res = add_res;
        alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                  (add_res[WIDTH-1] != bus.a[WIDTH-1]);
      end
      F_SUB: begin
        alu_res = sub_res;
        alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                  (sub_res[WIDTH-1] != bus.a[WIDTH-1]);
      end
      F_SLT:  alu_res[0] = $signed(bus.a) < $signed(bus.b);
      F_MFHI: alu_res = hi;
      F_MFLO: alu_res = lo;
      default: begin
        alu_res = '0;
        alu_ovf = 1'b0;
      end
    endcase
  end

  // Per-iteration step values; SRL reuses the low half of prod as its working register
  always_comb begin
    sh_next   = prod[WIDTH-1:0] >> 1;
    mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, a_q} : '0);
    mul_next  = {mul_sum, prod[WIDTH-1:1]};
    last_iter = (cnt == CW'(1));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.funct == F_SRL)        state_nx = (bus.shamt == '0) ? DONE : SHIFT;
          else if (bus.funct == F_MULTU) state_nx = MULT;
          else                           state_nx = DONE;
        end
      end
      SHIFT:   if (last_iter) state_nx = DONE;
      MULT:    if (last_iter) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    bus.busy = (state != IDLE);
    bus.done = (state == DONE);
  end

  // Operand latch, iteration registers, HI/LO and registered result/flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q          <= '0;
      prod         <= '0;
      cnt          <= '0;
      hi           <= '0;
      lo           <= '0;
      bus.result   <= '0;
      bus.zero     <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q <= bus.a;
            if (bus.funct == F_SRL) begin
              prod <= {{WIDTH{1'b0}}, bus.b};
              cnt  <= {1'b0, bus.shamt};
              if (bus.shamt == '0) begin
                bus.result   <= bus.b;
                bus.zero     <= (bus.b == '0);
                bus.overflow <= 1'b0;
              end
            end else if (bus.funct == F_MULTU) begin
              prod <= {{WIDTH{1'b0}}, bus.b};
              cnt  <= CW'(WIDTH);
            end else begin
              bus.result   <= alu_res;
              bus.zero     <= (alu_res == '0);
              bus.overflow <= alu_ovf;
            end
          end
        end
        SHIFT: begin
          prod[WIDTH-1:0] <= sh_next;
          cnt             <= cnt - CW'(1);
          if (last_iter) begin
            bus.result   <= sh_next;
            bus.zero     <= (sh_next == '0);
            bus.overflow <= 1'b0;
          end
        end
        MULT: begin
          prod <= mul_next;
          cnt  <= cnt - CW'(1);
          if (last_iter) begin
            hi           <= mul_next[2*WIDTH-1:WIDTH];
            lo           <= mul_next[WIDTH-1:0];
            bus.result   <= mul_next[WIDTH-1:0];
            bus.zero     <= (mul_next[WIDTH-1:0] == '0);
            bus.overflow <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu.
module tb_seq_alu;

  localparam int W  = 32;
  localparam int SW = 5;

  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_BAD   = 6'b111111;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  seq_alu_if #(.WIDTH(W), .SHW(SW)) bus ();

  seq_alu #(.WIDTH(W), .SHW(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Issue one op; lat = cycles from accept edge until done is seen (-1 on timeout)
  task automatic run_op(input logic [5:0] f, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [SW-1:0] sh, output int lat);
    @(negedge clk);
    bus.start = 1'b1; bus.funct = f; bus.a = av; bus.b = bv; bus.shamt = sh;
    @(negedge clk);
    bus.start = 1'b0; bus.a = ~av; bus.b = ~bv; bus.shamt = ~sh;
    lat = 1;
    while (bus.done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (bus.done !== 1'b1) lat = -1;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.funct = '0; bus.a = '0; bus.b = '0; bus.shamt = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_checks++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", bus.result); end
    n_checks++; if (bus.zero !== 1'b0) begin n_fail++; $display("FAIL reset_zero: got %b want 0", bus.zero); end
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", bus.overflow); end
  endtask

  task automatic test_add_overflow();
    int lat;
    run_op(F_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, lat);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL add_latency: got %0d want 1", lat); end
    n_checks++; if (bus.result !== 32'h8000_0000) begin n_fail++; $display("FAIL add_result: got %h want 80000000", bus.result); end
    n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL add_ovf: got %b want 1", bus.overflow); end
    n_checks++; if (bus.zero !== 1'b0) begin n_fail++; $display("FAIL add_zero: got %b want 0", bus.zero); end
    @(negedge clk);
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL add_done_pulse: got %b want 0", bus.done); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL add_busy_after: got %b want 0", bus.busy); end
    n_checks++; if (bus.result !== 32'h8000_0000) begin n_fail++; $display("FAIL add_result_hold: got %h want 80000000", bus.result); end
  endtask

  task automatic test_sub_slt_logic();
    int lat;
    run_op(F_SUB, 32'd5, 32'd5, 5'd0, lat);
    n_checks++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL sub_result: got %h want 0", bus.result); end
    n_checks++; if (bus.zero !== 1'b1) begin n_fail++; $display("FAIL sub_zero: got %b want 1", bus.zero); end
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL sub_ovf: got %b want 0", bus.overflow); end
    run_op(F_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, lat);
    n_checks++; if (bus.result !== 32'h1) begin n_fail++; $display("FAIL slt_result: got %h want 1", bus.result); end
    n_checks++; if (bus.zero !== 1'b0) begin n_fail++; $display("FAIL slt_zero: got %b want 0", bus.zero); end
    run_op(F_SUB, 32'h8000_0000, 32'h0000_0001, 5'd0, lat);
    n_checks++; if (bus.result !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL sub_ovf_result: got %h want 7fffffff", bus.result); end
    n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL sub_ovf_flag: got %b want 1", bus.overflow); end
    run_op(F_AND, 32'h0000_F0F0, 32'h0000_FF00, 5'd0, lat);
    n_checks++; if (bus.result !== 32'h0000_F000) begin n_fail++; $display("FAIL and_result: got %h want 0000f000", bus.result); end
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL and_ovf: got %b want 0", bus.overflow); end
    run_op(F_OR, 32'h0000_F0F0, 32'h0000_FF00, 5'd0, lat);
    n_checks++; if (bus.result !== 32'h0000_FFF0) begin n_fail++; $display("FAIL or_result: got %h want 0000fff0", bus.result); end
    run_op(F_BAD, 32'h1234_5678, 32'h1111_1111, 5'd3, lat);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL bad_latency: got %0d want 1", lat); end
    n_checks++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL bad_result: got %h want 0", bus.result); end
    n_checks++; if (bus.zero !== 1'b1) begin n_fail++; $display("FAIL bad_zero: got %b want 1", bus.zero); end
  endtask

  task automatic test_srl();
    int lat;
    run_op(F_SRL, 32'h0, 32'h8000_0000, 5'd31, lat);
    n_checks++; if (lat !== 32) begin n_fail++; $display("FAIL srl31_latency: got %0d want 32", lat); end
    n_checks++; if (bus.result !== 32'h1) begin n_fail++; $display("FAIL srl31_result: got %h want 1", bus.result); end
    run_op(F_SRL, 32'h0, 32'h0000_1234, 5'd0, lat);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL srl0_latency: got %0d want 1", lat); end
    n_checks++; if (bus.result !== 32'h0000_1234) begin n_fail++; $display("FAIL srl0_result: got %h want 1234", bus.result); end
    run_op(F_SRL, 32'h0, 32'hF000_0000, 5'd4, lat);
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL srl4_latency: got %0d want 5", lat); end
    n_checks++; if (bus.result !== 32'h0F00_0000) begin n_fail++; $display("FAIL srl4_result: got %h want 0f000000", bus.result); end
  endtask

  task automatic test_busy_ignore();
    int lat;
    int ndone = 0;
    int first = -1;
    logic [W-1:0] res = '0;
    logic busy_mid = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.funct = F_MULTU; bus.a = 32'd3; bus.b = 32'd4;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (bus.done === 1'b1) begin
        ndone++;
        if (ndone == 1) begin first = c; res = bus.result; end
      end
      if (c == 3) begin
        busy_mid = bus.busy;
        bus.start = 1'b1; bus.funct = F_ADD; bus.a = 32'd1; bus.b = 32'd1;
      end else if (c == 4) begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    n_checks++; if (busy_mid !== 1'b1) begin n_fail++; $display("FAIL ign_busy: got %b want 1", busy_mid); end
    n_checks++; if (ndone !== 1) begin n_fail++; $display("FAIL ign_done_count: got %0d want 1", ndone); end
    n_checks++; if (first !== 33) begin n_fail++; $display("FAIL ign_latency: got %0d want 33", first); end
    n_checks++; if (res !== 32'd12) begin n_fail++; $display("FAIL ign_result: got %h want c", res); end
    run_op(F_MFLO, 32'h0, 32'h0, 5'd0, lat);
    n_checks++; if (bus.result !== 32'd12) begin n_fail++; $display("FAIL ign_mflo: got %h want c", bus.result); end
  endtask

  task automatic test_multu();
    int lat;
    run_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, lat);
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL mul_latency: got %0d want 33", lat); end
    n_checks++; if (bus.result !== 32'h1) begin n_fail++; $display("FAIL mul_result: got %h want 1", bus.result); end
    run_op(F_MFHI, 32'h0, 32'h0, 5'd0, lat);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL mfhi_latency: got %0d want 1", lat); end
    n_checks++; if (bus.result !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mfhi_result: got %h want fffffffe", bus.result); end
    run_op(F_ADD, 32'd7, 32'd8, 5'd0, lat);
    run_op(F_MFLO, 32'h0, 32'h0, 5'd0, lat);
    n_checks++; if (bus.result !== 32'h1) begin n_fail++; $display("FAIL mflo_result: got %h want 1", bus.result); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.start = 1'b1; bus.funct = F_AND; bus.a = 32'hF0F0_F0F0; bus.b = 32'hFF00_FF00;
    @(negedge clk);
    n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL b2b_done1: got %b want 1", bus.done); end
    n_checks++; if (bus.result !== 32'hF000_F000) begin n_fail++; $display("FAIL b2b_and: got %h want f000f000", bus.result); end
    bus.funct = F_ADD; bus.a = 32'd2; bus.b = 32'd3;
    @(negedge clk);
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL b2b_no_done: got %b want 0", bus.done); end
    n_checks++; if (bus.result !== 32'hF000_F000) begin n_fail++; $display("FAIL b2b_ignored: got %h want f000f000", bus.result); end
    bus.funct = F_OR; bus.a = 32'h0000_000F; bus.b = 32'h0000_00F0;
    @(negedge clk);
    bus.start = 1'b0;
    n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL b2b_done2: got %b want 1", bus.done); end
    n_checks++; if (bus.result !== 32'h0000_00FF) begin n_fail++; $display("FAIL b2b_or: got %h want ff", bus.result); end
    @(negedge clk);
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_end: got %b want 0", bus.done); end
  endtask

  task automatic test_reset_abort();
    int lat;
    int ndone = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.funct = F_MULTU; bus.a = 32'hFFFF_FFFF; bus.b = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b want 0", bus.done); end
    n_checks++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL abort_result: got %h want 0", bus.result); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) ndone++;
    end
    n_checks++; if (ndone !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d want 0", ndone); end
    run_op(F_MFHI, 32'h0, 32'h0, 5'd0, lat);
    n_checks++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL abort_mfhi: got %h want 0", bus.result); end
    run_op(F_MFLO, 32'h0, 32'h0, 5'd0, lat);
    n_checks++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL abort_mflo: got %h want 0", bus.result); end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_sub_slt_logic();
    test_srl();
    test_busy_ignore();
    test_multu();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
